// File: rtl/kan_tda_agg_pkg.sv
// kan_tda_agg_pkg
// Shared definitions for the KAN/TDA result aggregator:
//   - agg_state_t   : collector FSM states
//   - size helpers  : beat count and beat-index width for any configuration
//   - word offsets  : where a KAN or TDA source word sits in the packed buffer
//   - NUM_SRC/BUF_WORDS/BEATS/BEAT_W : sizes of the default build
package kan_tda_agg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } agg_state_t;

  // KAN source i, word w sits at i*kan_words + w.
  function automatic int kan_word_offset(input int i, input int w, input int kan_words);
    return i * kan_words + w;
  endfunction

  // TDA words follow the whole KAN region (kan_base = NUM_KAN_SRC*KAN_WORDS).
  function automatic int tda_word_offset(input int j, input int w, input int kan_base,
                                         input int tda_words);
    return kan_base + j * tda_words + w;
  endfunction

  function automatic int calc_beats(input int buf_words, input int lanes);
    return (buf_words + lanes - 1) / lanes;
  endfunction

  // A single-beat buffer still gets a 1-bit beat index.
  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int DEF_NUM_KAN_SRC = 16;
  localparam int DEF_NUM_TDA_SRC = 4;
  localparam int DEF_KAN_WORDS   = 4;
  localparam int DEF_TDA_WORDS   = 16;
  localparam int DEF_OUT_LANES   = 8;

  localparam int NUM_SRC   = DEF_NUM_KAN_SRC + DEF_NUM_TDA_SRC;
  localparam int BUF_WORDS = DEF_NUM_KAN_SRC * DEF_KAN_WORDS + DEF_NUM_TDA_SRC * DEF_TDA_WORDS;
  localparam int BEATS     = calc_beats(BUF_WORDS, DEF_OUT_LANES);
  localparam int BEAT_W    = beat_width(BEATS);

endpackage

// File: rtl/kan_tda_agg_src_slot.sv
// kan_tda_agg_src_slot
// Capture slot for one result source: holds the source's words, its
// captured bit and a one-cycle acknowledge.
//   domain_clocks/domain_resets : clock, async active-low reset
//   i_clear    : start of round, zeroes data and captured bit
//   i_collect  : collector is in COLLECT (and not being aborted)
//   i_enable   : source participates in this round (latched enable)
//   i_valid    : source result valid
//   i_data     : source words, word w at [w*DATA_WIDTH +: DATA_WIDTH]
//   o_capture  : capture happens at the coming edge (combinational)
//   o_captured : source already captured this round
//   o_ack      : high for the cycle after the capture edge
//   o_data     : captured words (zero until captured)
module kan_tda_agg_src_slot
  import kan_tda_agg_pkg::*;
#(
  parameter int WORDS      = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        domain_clocks,
  input  logic                        domain_resets,
  input  logic                        i_clear,
  input  logic                        i_collect,
  input  logic                        i_enable,
  input  logic                        i_valid,
  input  logic [WORDS*DATA_WIDTH-1:0] i_data,
  output logic                        o_capture,
  output logic                        o_captured,
  output logic                        o_ack,
  output logic [WORDS*DATA_WIDTH-1:0] o_data
);

  logic [WORDS*DATA_WIDTH-1:0] r_data;
  logic                        r_captured;
  logic                        r_ack;
  logic                        w_capture;

  // A source is taken at most once per round; later valids are ignored.
  assign w_capture = i_collect & i_enable & i_valid & ~r_captured;

  always_ff @(posedge domain_clocks or negedge domain_resets) begin
    if (!domain_resets) begin
      r_data     <= '0;
      r_captured <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      r_ack <= w_capture;
      if (i_clear) begin
        r_data     <= '0;
        r_captured <= 1'b0;
      end else if (w_capture) begin
        r_data     <= i_data;
        r_captured <= 1'b1;
      end
    end
  end

  assign o_capture  = w_capture;
  assign o_captured = r_captured;
  assign o_ack      = r_ack;
  assign o_data     = r_data;

endmodule

// File: rtl/kan_tda_result_aggregator.sv
// kan_tda_result_aggregator
// Collects one round of results from NUM_KAN_SRC KAN cores and NUM_TDA_SRC
// TDA engines into a packed buffer, then streams it out in OUT_LANES-word
// beats. Rounds end when every enabled source is captured or on timeout.
//   domain_clocks/domain_resets : clock, async active-low reset
//   round_start/soft_clear      : start a round (IDLE only) / abort to IDLE
//   src_enable                  : participating sources, KAN low, TDA high
//   kan_valid/kan_data/kan_ack  : KAN capture interface
//   tda_valid/tda_data/tda_ack  : TDA capture interface
//   out_data/out_valid/out_ready/out_last/out_beat : output beat stream
//   round_busy/computation_done : status
//   timeout_flag/missing_mask   : outcome of the last round
//   o_dbg_state                 : current FSM state
// Output handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high; while out_ready is low, out_data, out_beat and
// out_last hold. Source capture: valid high before an edge in COLLECT
// captures an enabled, not-yet-captured source; ack answers in the next cycle.
module kan_tda_result_aggregator
  import kan_tda_agg_pkg::*;
#(
  parameter int NUM_KAN_SRC    = 16,
  parameter int NUM_TDA_SRC    = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int KAN_WORDS      = 4,
  parameter int TDA_WORDS      = 16,
  parameter int OUT_LANES      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                         domain_clocks,
  input  logic                                         domain_resets,
  input  logic                                         round_start,
  input  logic                                         soft_clear,
  input  logic [NUM_KAN_SRC+NUM_TDA_SRC-1:0]           src_enable,
  input  logic [NUM_KAN_SRC-1:0]                       kan_valid,
  input  logic [NUM_KAN_SRC*KAN_WORDS*DATA_WIDTH-1:0]  kan_data,
  output logic [NUM_KAN_SRC-1:0]                       kan_ack,
  input  logic [NUM_TDA_SRC-1:0]                       tda_valid,
  input  logic [NUM_TDA_SRC*TDA_WORDS*DATA_WIDTH-1:0]  tda_data,
  output logic [NUM_TDA_SRC-1:0]                       tda_ack,
  output logic [OUT_LANES*DATA_WIDTH-1:0]              out_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         out_last,
  output logic [beat_width(calc_beats(NUM_KAN_SRC*KAN_WORDS+NUM_TDA_SRC*TDA_WORDS,
                                      OUT_LANES))-1:0] out_beat,
  output logic                                         round_busy,
  output logic                                         computation_done,
  output logic                                         timeout_flag,
  output logic [NUM_KAN_SRC+NUM_TDA_SRC-1:0]           missing_mask,
  output agg_state_t                                   o_dbg_state
);

  localparam int L_NUM_SRC   = NUM_KAN_SRC + NUM_TDA_SRC;
  localparam int L_KAN_BASE  = NUM_KAN_SRC * KAN_WORDS;
  localparam int L_BUF_WORDS = L_KAN_BASE + NUM_TDA_SRC * TDA_WORDS;
  localparam int L_BEATS     = calc_beats(L_BUF_WORDS, OUT_LANES);
  localparam int L_BEAT_W    = beat_width(L_BEATS);
  localparam int L_BEAT_BITS = OUT_LANES * DATA_WIDTH;
  localparam int L_PAD_WORDS = L_BEATS * OUT_LANES - L_BUF_WORDS;
  localparam int L_CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  agg_state_t                       r_state, w_next_state;
  logic [L_NUM_SRC-1:0]             r_enable;
  logic [L_NUM_SRC-1:0]             r_missing;
  logic                             r_timeout_flag;
  logic [L_CNT_W-1:0]               r_cnt;
  logic [L_BEAT_W-1:0]              r_beat;

  logic [L_NUM_SRC-1:0]             w_capture, w_captured, w_ack, w_done_mask;
  logic [L_BEATS*L_BEAT_BITS-1:0]   w_buf;
  logic                             w_start, w_collect, w_complete, w_timeout, w_last;

  assign w_start     = (r_state == ST_IDLE) & round_start & ~soft_clear;
  assign w_collect   = (r_state == ST_COLLECT) & ~soft_clear;
  assign w_done_mask = w_captured | w_capture;
  assign w_complete  = (w_done_mask == r_enable);
  // The counter reaches zero on the edge where it currently reads one.
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == L_CNT_W'(1));
  assign w_last      = (r_beat == L_BEAT_W'(L_BEATS - 1));

  for (genvar i = 0; i < NUM_KAN_SRC; i++) begin : g_kan
    kan_tda_agg_src_slot #(.WORDS(KAN_WORDS), .DATA_WIDTH(DATA_WIDTH)) u_slot (
      .domain_clocks (domain_clocks),
      .domain_resets (domain_resets),
      .i_clear       (w_start),
      .i_collect     (w_collect),
      .i_enable      (r_enable[i]),
      .i_valid       (kan_valid[i]),
      .i_data        (kan_data[i*KAN_WORDS*DATA_WIDTH +: KAN_WORDS*DATA_WIDTH]),
      .o_capture     (w_capture[i]),
      .o_captured    (w_captured[i]),
      .o_ack         (w_ack[i]),
      .o_data        (w_buf[kan_word_offset(i, 0, KAN_WORDS)*DATA_WIDTH +: KAN_WORDS*DATA_WIDTH])
    );
  end

  for (genvar j = 0; j < NUM_TDA_SRC; j++) begin : g_tda
    kan_tda_agg_src_slot #(.WORDS(TDA_WORDS), .DATA_WIDTH(DATA_WIDTH)) u_slot (
      .domain_clocks (domain_clocks),
      .domain_resets (domain_resets),
      .i_clear       (w_start),
      .i_collect     (w_collect),
      .i_enable      (r_enable[NUM_KAN_SRC+j]),
      .i_valid       (tda_valid[j]),
      .i_data        (tda_data[j*TDA_WORDS*DATA_WIDTH +: TDA_WORDS*DATA_WIDTH]),
      .o_capture     (w_capture[NUM_KAN_SRC+j]),
      .o_captured    (w_captured[NUM_KAN_SRC+j]),
      .o_ack         (w_ack[NUM_KAN_SRC+j]),
      .o_data        (w_buf[tda_word_offset(j, 0, L_KAN_BASE, TDA_WORDS)*DATA_WIDTH
                            +: TDA_WORDS*DATA_WIDTH])
    );
  end

  // Lanes past the end of the buffer in the final beat read zero.
  if (L_PAD_WORDS > 0) begin : g_pad
    assign w_buf[L_BEATS*L_BEAT_BITS-1 : L_BUF_WORDS*DATA_WIDTH] = '0;
  end

  always_ff @(posedge domain_clocks or negedge domain_resets) begin
    if (!domain_resets) r_state <= ST_IDLE;
    else                r_state <= w_next_state;
  end

  always_comb begin
    w_next_state     = r_state;
    out_valid        = 1'b0;
    computation_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // An empty enable set has nothing to wait for.
        if (round_start) w_next_state = (src_enable == '0) ? ST_DRAIN : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_complete || w_timeout) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && w_last) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        computation_done = 1'b1;
        w_next_state     = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (soft_clear) w_next_state = ST_IDLE;
  end

  always_ff @(posedge domain_clocks or negedge domain_resets) begin
    if (!domain_resets) begin
      r_enable       <= '0;
      r_missing      <= '0;
      r_timeout_flag <= 1'b0;
      r_cnt          <= '0;
      r_beat         <= '0;
    end else begin
      if (w_start) begin
        r_enable       <= src_enable;
        r_cnt          <= L_CNT_W'(TIMEOUT_CYCLES);
        r_timeout_flag <= 1'b0;
        r_missing      <= '0;
      end else if (w_collect) begin
        if (TIMEOUT_CYCLES != 0 && r_cnt != '0) r_cnt <= r_cnt - L_CNT_W'(1);
        // Completion wins; captures on the timeout edge count as captured.
        if (w_timeout && !w_complete) begin
          r_timeout_flag <= 1'b1;
          r_missing      <= r_enable & ~w_done_mask;
        end
      end
      if (soft_clear || w_start)        r_beat <= '0;
      else if (out_valid && out_ready)  r_beat <= w_last ? '0 : r_beat + L_BEAT_W'(1);
    end
  end

  assign out_data     = w_buf[int'(r_beat)*L_BEAT_BITS +: L_BEAT_BITS];
  assign out_beat     = r_beat;
  assign out_last     = (r_state == ST_DRAIN) & w_last;
  assign round_busy   = (r_state != ST_IDLE);
  assign kan_ack      = w_ack[NUM_KAN_SRC-1:0];
  assign tda_ack      = w_ack[L_NUM_SRC-1:NUM_KAN_SRC];
  assign timeout_flag = r_timeout_flag;
  assign missing_mask = r_missing;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_kan_tda_result_aggregator.sv
// tb_kan_tda_result_aggregator
// Directed sequence of rounds with randomized valid timing, ready patterns
// and data, checked against a word-level model of the result buffer.
module tb_kan_tda_result_aggregator;
  import kan_tda_agg_pkg::*;

  localparam int NK = 16, NT = 4, DW = 16, KW = 4, TW = 16, OL = 8, TO = 100;
  localparam int NS = NUM_SRC, NB = BEATS, BW_BITS = OL * DW;

  logic                  domain_clocks, domain_resets;
  logic                  round_start, soft_clear, out_ready;
  logic [NS-1:0]         src_enable, missing_mask;
  logic [NK-1:0]         kan_valid, kan_ack;
  logic [NT-1:0]         tda_valid, tda_ack;
  logic [NK*KW*DW-1:0]   kan_data;
  logic [NT*TW*DW-1:0]   tda_data;
  logic [BW_BITS-1:0]    out_data;
  logic                  out_valid, out_last, round_busy, computation_done, timeout_flag;
  logic [BEAT_W-1:0]     out_beat;
  agg_state_t            dbg_state;

  kan_tda_result_aggregator #(
    .NUM_KAN_SRC(NK), .NUM_TDA_SRC(NT), .DATA_WIDTH(DW), .KAN_WORDS(KW),
    .TDA_WORDS(TW), .OUT_LANES(OL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .domain_clocks(domain_clocks), .domain_resets(domain_resets),
    .round_start(round_start), .soft_clear(soft_clear), .src_enable(src_enable),
    .kan_valid(kan_valid), .kan_data(kan_data), .kan_ack(kan_ack),
    .tda_valid(tda_valid), .tda_data(tda_data), .tda_ack(tda_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_beat(out_beat), .round_busy(round_busy),
    .computation_done(computation_done), .timeout_flag(timeout_flag),
    .missing_mask(missing_mask), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial domain_clocks = 1'b0;
  always #5 domain_clocks = ~domain_clocks;

  // ---------------- bookkeeping ----------------
  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [15:0]        salt;
  logic [NS-1:0]      ena;
  int                 d[NS];        // cycle at which a source raises valid, -1 = never
  int                 ack_cnt[NS], ack_cyc[NS];
  int                 col_cyc;
  logic [BW_BITS-1:0] got[NB];
  logic [BW_BITS-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] src_word(input int s, input int w);
    int v;
    if (s < NK) v = s * 256 + w;
    else        v = 32'h8000 + (s - NK) * 256 + w;
    return v[15:0] ^ salt;
  endfunction

  // ---------------- drivers ----------------
  task automatic start_round(input logic [NS-1:0] en);
    ena = en;
    for (int s = 0; s < NK; s++)
      for (int w = 0; w < KW; w++) kan_data[(s*KW+w)*DW +: DW] = src_word(s, w);
    for (int j = 0; j < NT; j++)
      for (int w = 0; w < TW; w++) tda_data[(j*TW+w)*DW +: DW] = src_word(NK + j, w);
    src_enable  = en;
    round_start = 1'b1;
    @(negedge domain_clocks);
    round_start = 1'b0;
    src_enable  = NS'($urandom);   // enable must have been latched already
  endtask

  task automatic collect();
    for (int s = 0; s < NS; s++) begin ack_cnt[s] = 0; ack_cyc[s] = -1; end
    col_cyc = 0;
    while (!out_valid && col_cyc < 300) begin
      for (int s = 0; s < NS; s++) begin
        if (s < NK) kan_valid[s]    = (d[s] >= 0) && (col_cyc >= d[s]);
        else        tda_valid[s-NK] = (d[s] >= 0) && (col_cyc >= d[s]);
      end
      @(negedge domain_clocks);
      col_cyc++;
      for (int s = 0; s < NS; s++)
        if ((s < NK) ? kan_ack[s] : tda_ack[s-NK]) begin ack_cnt[s]++; ack_cyc[s] = col_cyc; end
    end
    kan_valid = '0;
    tda_valid = '0;
    check("drain_reached", out_valid, 1'b1);
  endtask

  // Reference: derives captures, timing and the buffer image from the round setup.
  task automatic check_round(input string tag);
    logic [NS-1:0]      cap, miss, once, timely;
    logic [DW-1:0]      words[BUF_WORDS];
    logic [BW_BITS-1:0] beat;
    int maxd, exp_cyc, idx;
    cap = '0; maxd = -1;
    for (int s = 0; s < NS; s++)
      if (ena[s] && d[s] >= 0 && d[s] < TO) begin
        cap[s] = 1'b1;
        if (d[s] > maxd) maxd = d[s];
      end
    miss    = ena & ~cap;
    exp_cyc = (miss != '0) ? TO : ((ena == '0) ? 0 : maxd + 1);
    for (int s = 0; s < NS; s++) begin
      once[s]   = (ack_cnt[s] == 1);
      timely[s] = (ack_cyc[s] == d[s] + 1);
    end
    check({tag, "_drain_cycle"}, col_cyc, exp_cyc);
    check({tag, "_ack_once"}, once, cap);
    check({tag, "_ack_timing"}, timely, cap);
    check({tag, "_timeout_flag"}, timeout_flag, (miss != '0));
    check({tag, "_missing_mask"}, missing_mask, miss);
    for (int i = 0; i < BUF_WORDS; i++) words[i] = '0;
    for (int s = 0; s < NS; s++)
      if (cap[s]) begin
        if (s < NK) for (int w = 0; w < KW; w++) words[s*KW+w] = src_word(s, w);
        else        for (int w = 0; w < TW; w++) words[NK*KW+(s-NK)*TW+w] = src_word(s, w);
      end
    exp_q.delete();
    for (int b = 0; b < NB; b++) begin
      for (int l = 0; l < OL; l++) begin
        idx = b * OL + l;
        beat[l*DW +: DW] = (idx < BUF_WORDS) ? words[idx] : '0;
      end
      exp_q.push_back(beat);
    end
  endtask

  // mode 0: always ready, 1: ready one cycle in three, 2: random.
  task automatic drain(input string tag, input int mode, input int stop_at);
    int hs, cyc;
    logic stalled, rdy;
    logic [BW_BITS-1:0] pd, ev;
    logic [BEAT_W-1:0]  pb;
    hs = 0; cyc = 0; stalled = 1'b0; pd = '0; pb = '0;
    while (hs < NB && hs != stop_at && cyc < 600) begin
      if (stalled) begin
        check({tag, "_stall_data"}, out_data, pd);
        check({tag, "_stall_beat"}, out_beat, pb);
      end
      rdy = (mode == 0) ? 1'b1 : ((mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1)));
      out_ready = rdy;
      if (rdy && out_valid) begin
        check({tag, "_beat_idx"}, out_beat, hs);
        check({tag, "_last"}, out_last, (hs == NB - 1));
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_data"}, out_data, ev);
        got[hs] = out_data;
        hs++;
      end
      pd = out_data; pb = out_beat; stalled = !rdy;
      @(negedge domain_clocks);
      cyc++;
    end
    out_ready = 1'b0;
    if (stop_at < 0) begin
      check({tag, "_handshakes"}, hs, NB);
      check({tag, "_done_pulse"}, {computation_done, out_valid}, 2'b10);
      @(negedge domain_clocks);
      check({tag, "_done_end"}, {computation_done, round_busy}, 2'b00);
    end
  endtask

  task automatic rand_delays(input int lo, input int hi);
    for (int s = 0; s < NS; s++) d[s] = $urandom_range(lo, hi);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_flags"}, {round_busy, out_valid, out_last, computation_done, timeout_flag}, 5'b0);
    check({tag, "_acks"}, {kan_ack, tda_ack}, '0);
    check({tag, "_missing"}, missing_mask, '0);
    check({tag, "_out"}, {out_data, out_beat}, '0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  int saved_d[NS];
  logic done_seen;

  initial begin
    domain_resets = 1'b0; round_start = 1'b0; soft_clear = 1'b0; out_ready = 1'b0;
    src_enable = '0; kan_valid = '0; tda_valid = '0; kan_data = '0; tda_data = '0;
    salt = '0;
    #3;
    check_quiet("reset");
    @(negedge domain_clocks);
    @(negedge domain_clocks);
    domain_resets = 1'b1;
    @(negedge domain_clocks);

    // All sources, staggered valids, always ready.
    rand_delays(0, 40);
    for (int s = 0; s < NS; s++) saved_d[s] = d[s];
    start_round('1);
    collect();
    check_round("full");
    drain("full", 0, -1);
    check("full_beat0", got[0], 128'h0103_0102_0101_0100_0003_0002_0001_0000);

    // Same round under backpressure.
    for (int s = 0; s < NS; s++) d[s] = saved_d[s];
    start_round('1);
    collect();
    check_round("bp");
    drain("bp", 1, -1);

    // TDA source 2 never answers: timeout.
    rand_delays(0, 40);
    d[18] = -1;
    start_round('1);
    collect();
    check_round("tmo");
    check("tmo_cycles", col_cyc, TO);
    check("tmo_mask", missing_mask, 20'h40000);
    drain("tmo", 2, -1);
    check("tmo_beats12_13", {got[12], got[13]}, 256'h0);

    // Everything valid at once, source 5 disabled but valid.
    for (int s = 0; s < NS; s++) d[s] = 0;
    start_round(~(20'h1 << 5));
    collect();
    check_round("burst");
    check("burst_ack5", ack_cnt[5], 0);
    drain("burst", 0, -1);
    check("burst_words20_23", got[2][127:64], 64'h0);

    // Timeout round aborted mid-drain; flags survive the abort.
    rand_delays(0, 30);
    d[19] = -1;
    start_round('1);
    collect();
    check_round("abort");
    drain("abort", 0, 5);
    check("abort_at_beat5", {out_valid, out_beat}, {1'b1, 4'd5});
    soft_clear = 1'b1;
    @(negedge domain_clocks);
    soft_clear = 1'b0;
    check("abort_idle", {round_busy, out_valid, dbg_state}, {1'b0, 1'b0, ST_IDLE});
    check("abort_flags_kept", {timeout_flag, missing_mask}, {1'b1, 20'h80000});
    done_seen = 1'b0;
    repeat (4) begin
      if (computation_done) done_seen = 1'b1;
      @(negedge domain_clocks);
    end
    check("abort_no_done", done_seen, 1'b0);

    // Normal round after the abort.
    rand_delays(0, 40);
    start_round('1);
    collect();
    check_round("post_abort");
    drain("post_abort", 2, -1);

    // Random data, random enables, occasional silent sources.
    repeat (2) begin
      salt = 16'($urandom);
      for (int s = 0; s < NS; s++) d[s] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 60));
      start_round(NS'($urandom));
      collect();
      check_round("rand");
      drain("rand", 2, -1);
    end
    salt = '0;

    // Nothing enabled: straight to drain, all-zero beats.
    start_round('0);
    col_cyc = 0;
    for (int s = 0; s < NS; s++) begin ack_cnt[s] = 0; ack_cyc[s] = -1; d[s] = -1; end
    check_round("empty");
    drain("empty", 0, -1);

    // Asynchronous reset in the middle of collection.
    start_round('1);
    kan_valid = '1;
    @(negedge domain_clocks);
    check("pre_reset_acks", kan_ack, 16'hffff);
    #2 domain_resets = 1'b0;
    #1 check_quiet("async_reset");
    kan_valid = '0;
    @(negedge domain_clocks);
    domain_resets = 1'b1;
    @(negedge domain_clocks);
    check("post_reset_state", dbg_state, ST_IDLE);
    rand_delays(0, 40);
    start_round('1);
    collect();
    check_round("post_reset");
    drain("post_reset", 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
